// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Handshake: imem_addr must stay stable while imem_req=1 until imem_ack=1; imem_ack may
// rise in the same cycle as imem_req, and imem_rdata is meaningful only when imem_ack=1.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over the imem handshake and hands instrF/PCF to IF/ID,
// squashing fetches made stale by execute-stage redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  fetch_unit_if.master          imem,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  fetch_validF,
  output fetch_state_t          state_dbg
);

  localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  fetch_state_t          state_q, state_n;
  logic [DATA_WIDTH-1:0] pc_q, pc_n;
  logic [DATA_WIDTH-1:0] buf_q, buf_n;
  logic [DATA_WIDTH-1:0] drop_q, drop_n;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] pc_plus4;

  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  valid;
  logic [DATA_WIDTH-1:0] instr;

  assign target   = PCTargetE & ALIGN_MASK;
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // Next-state decode; a redirect always wins over a stall.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    buf_n   = buf_q;
    drop_n  = drop_q;
    case (state_q)
      IDLE: begin
        state_n = FETCH;
        if (PCSrcE) pc_n = target;
      end
      FETCH: begin
        if (PCSrcE) begin
          pc_n = target;
          // An unanswered request cannot be withdrawn, so its answer must be absorbed first.
          if (!imem.imem_ack) begin
            drop_n  = pc_q;
            state_n = DROP;
          end
        end else if (imem.imem_ack) begin
          if (stallF) begin
            buf_n   = imem.imem_rdata;
            state_n = HOLD;
          end else begin
            pc_n = pc_plus4;
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (!stallF) begin
          pc_n    = pc_plus4;
          state_n = FETCH;
        end
      end
      DROP: begin
        if (PCSrcE) pc_n = target;
        if (imem.imem_ack) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req   = 1'b0;
    addr  = pc_q;
    valid = 1'b0;
    instr = NOP;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (imem.imem_ack && !PCSrcE) begin
          valid = 1'b1;
          instr = imem.imem_rdata;
        end
      end
      HOLD: begin
        if (!PCSrcE) begin
          valid = 1'b1;
          instr = buf_q;
        end
      end
      DROP: begin
        req  = 1'b1;
        addr = drop_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      buf_q   <= NOP;
      drop_q  <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      buf_q   <= buf_n;
      drop_q  <= drop_n;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr & ALIGN_MASK;
  assign instrF         = instr;
  assign PCF            = pc_q;
  assign PCPlus4F       = pc_plus4;
  assign fetch_validF   = valid;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word i holds value i and answers whenever ack is driven.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        ack;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        fetch_validF;
  fetch_state_t state_dbg;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;

  fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  assign bus.imem_ack   = ack;
  assign bus.imem_rdata = {2'b00, bus.imem_addr[31:2]};

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stallF       (stallF),
    .PCSrcE       (PCSrcE),
    .PCTargetE    (PCTargetE),
    .imem         (bus.master),
    .instrF       (instrF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F),
    .fetch_validF (fetch_validF),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rise.
  task automatic drive(input logic s, input logic src, input logic [31:0] tgt, input logic a);
    @(negedge clk);
    stallF    = s;
    PCSrcE    = src;
    PCTargetE = tgt;
    ack       = a;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    stallF    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = '0;
    ack       = 1'b1;

    // reset state
    #2;
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(fetch_validF), 32'd0);
    check("rst_instr", instrF, NOP);
    check("rst_pc", PCF, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_after_rst", 32'(state_dbg), 32'(IDLE));
    check("idle_req", 32'(bus.imem_req), 32'd0);

    // 1: single-cycle memory streams one instruction per cycle
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      exp_word = exp_q.pop_front();
      check("t1_pc", PCF, 32'(i * 4));
      check("t1_valid", 32'(fetch_validF), 32'd1);
      check("t1_instr", instrF, exp_word);
    end

    // 2: three-cycle stall at PC=8
    exp_word = exp_q.pop_front();
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check("t2_pc_c0", PCF, 32'h8);
    check("t2_instr_c0", instrF, exp_word);
    check("t2_valid_c0", 32'(fetch_validF), 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      check("t2_state_hold", 32'(state_dbg), 32'(HOLD));
      check("t2_req_hold", 32'(bus.imem_req), 32'd0);
      check("t2_pc_hold", PCF, 32'h8);
      check("t2_instr_hold", instrF, exp_word);
      check("t2_valid_hold", 32'(fetch_validF), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_release_instr", instrF, 32'h2);
    check("t2_release_pc", PCF, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_pc_after", PCF, 32'hC);
    check("t2_instr_after", instrF, 32'h3);

    // 3: one wait cycle before ack
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t3_req_wait", 32'(bus.imem_req), 32'd1);
    check("t3_addr_wait", bus.imem_addr, 32'h10);
    check("t3_valid_wait", 32'(fetch_validF), 32'd0);
    check("t3_instr_wait", instrF, NOP);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_addr_ack", bus.imem_addr, 32'h10);
    check("t3_valid_ack", 32'(fetch_validF), 32'd1);
    check("t3_instr_ack", instrF, 32'h4);
    for (int i = 5; i < 8; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      check("t3_stream_pc", PCF, 32'(i * 4));
    end

    // 4: redirect to 0x101 (masked to 0x100) while 0x20 is outstanding
    drive(1'b0, 1'b1, 32'h101, 1'b0);
    check("t4_valid_redir", 32'(fetch_validF), 32'd0);
    check("t4_addr_redir", bus.imem_addr, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t4_state_drop", 32'(state_dbg), 32'(DROP));
    check("t4_req_drop", 32'(bus.imem_req), 32'd1);
    check("t4_addr_drop", bus.imem_addr, 32'h20);
    check("t4_pc_drop", PCF, 32'h100);
    check("t4_valid_drop", 32'(fetch_validF), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_stale_valid", 32'(fetch_validF), 32'd0);
    check("t4_stale_instr", instrF, NOP);
    check("t4_stale_addr", bus.imem_addr, 32'h20);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_new_state", 32'(state_dbg), 32'(FETCH));
    check("t4_new_addr", bus.imem_addr, 32'h100);
    check("t4_new_instr", instrF, 32'h40);
    check("t4_new_valid", 32'(fetch_validF), 32'd1);
    check("t4_pcplus4", PCPlus4F, 32'h104);

    // 5: redirect and stall together in HOLD
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check("t5_instr_pre", instrF, 32'h41);
    drive(1'b1, 1'b1, 32'h200, 1'b1);
    check("t5_state_hold", 32'(state_dbg), 32'(HOLD));
    check("t5_valid", 32'(fetch_validF), 32'd0);
    check("t5_instr", instrF, NOP);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_state_after", 32'(state_dbg), 32'(FETCH));
    check("t5_pc_after", PCF, 32'h200);

    // PC wrap at the top of the address space
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check("wrap_kill_valid", 32'(fetch_validF), 32'd0);
    check("wrap_kill_state", 32'(state_dbg), 32'(FETCH));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_pc", PCF, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4F, 32'h0);
    check("wrap_instr", instrF, 32'h3FFF_FFFF);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_pc_next", PCF, 32'h0);
    check("wrap_instr_next", instrF, 32'h0);

    // 6: asynchronous reset while waiting on 0x40
    drive(1'b0, 1'b1, 32'h40, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_pc_wait", PCF, 32'h40);
    check("t6_addr_wait", bus.imem_addr, 32'h40);
    #2;
    rst_n = 1'b0;
    ack   = 1'b1;
    #1;
    check("t6_rst_state", 32'(state_dbg), 32'(IDLE));
    check("t6_rst_pc", PCF, 32'h0);
    check("t6_rst_req", 32'(bus.imem_req), 32'd0);
    check("t6_rst_valid", 32'(fetch_validF), 32'd0);
    check("t6_rst_instr", instrF, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_late_ack_state", 32'(state_dbg), 32'(IDLE));
    check("t6_late_ack_valid", 32'(fetch_validF), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("t6_restart_pc", PCF, 32'h0);
    check("t6_restart_valid", 32'(fetch_validF), 32'd1);
    check("t6_restart_instr", instrF, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
